// File: rtl/nios_mul_seq_cell.sv
// nios_mul_seq_cell
//   Sequential WIDTH x WIDTH -> 2*WIDTH integer multiplier. Each operand can
//   independently be signed or unsigned. A single signed (TILE+1)x(TILE+1)
//   multiplier is reused over N*N steps, where N = WIDTH/TILE.
//   Step k = i*N + j multiplies tile a_i by tile b_j. Only the top tile of a
//   signed operand carries its sign; every other tile is zero-extended.
//   The tile multiply and the accumulate are in separate register stages, so
//   the multiplier and the 2*WIDTH adder are never in series.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   flush            cancel any in-flight operation (wins over handshakes)
//   in_valid/ready   operand handshake; in_src1/2, *_signed, in_hi latched on accept
//   out_valid/ready  result handshake; out_result/out_product held while stalled
//   out_result       upper (in_hi=1) or lower product half
//   out_product      full 2*WIDTH product
//   busy             high while in MUL or DRAIN
module nios_mul_seq_cell #(
  parameter int WIDTH = 32,
  parameter int TILE  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_src1,
  input  logic [WIDTH-1:0]   in_src2,
  input  logic               in_src1_signed,
  input  logic               in_src2_signed,
  input  logic               in_hi,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);
  localparam int N     = WIDTH / TILE;
  localparam int STEPS = N * N;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

  generate
    if ((WIDTH % TILE) != 0 || !(N == 1 || N == 2 || N == 4)) begin : g_bad_cfg
      $error("nios_mul_seq_cell: WIDTH/TILE must be exactly 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DRAIN, S_DONE} state_e;

  state_e            state_q;
  logic [KW-1:0]     k_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              a_sgn_q, b_sgn_q, hi_q;
  logic [PW-1:0]     prod_q, acc_q;
  logic              prod_vld_q;
  logic [WIDTH-1:0]  res_q;

  logic              accept;
  int                ti, tj;
  logic [TILE-1:0]   a_tile, b_tile;
  logic signed [TILE:0]     a_ext, b_ext;
  logic signed [2*TILE+1:0] tp;
  logic [PW-1:0]     prod_d, sum_d;

  assign in_ready    = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept      = in_valid & in_ready;
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_MUL) | (state_q == S_DRAIN);
  assign out_product = acc_q;
  assign out_result  = res_q;

  // Tile product for step k, already aligned to its weight (i+j)*TILE.
  always_comb begin
    ti     = int'(k_q) / N;
    tj     = int'(k_q) % N;
    a_tile = a_q[ti*TILE +: TILE];
    b_tile = b_q[tj*TILE +: TILE];
    a_ext  = {a_sgn_q & (ti == N-1) & a_tile[TILE-1], a_tile};
    b_ext  = {b_sgn_q & (tj == N-1) & b_tile[TILE-1], b_tile};
    tp     = a_ext * b_ext;
    // Sign-extend to the full product width (truncates when N=1; mod 2^PW).
    prod_d = PW'(tp) << ((ti + tj) * TILE);
    sum_d  = acc_q + prod_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_sgn_q    <= 1'b0;
      b_sgn_q    <= 1'b0;
      hi_q       <= 1'b0;
    end else if (flush) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q        <= in_src1;
            b_q        <= in_src2;
            a_sgn_q    <= in_src1_signed;
            b_sgn_q    <= in_src2_signed;
            hi_q       <= in_hi;
            acc_q      <= '0;
            k_q        <= '0;
            prod_vld_q <= 1'b0;
            state_q    <= S_MUL;
          end else if (state_q == S_DONE && out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          prod_q     <= prod_d;
          prod_vld_q <= 1'b1;
          if (prod_vld_q) acc_q <= sum_d;
          k_q <= k_q + KW'(1);
          if (k_q == K_LAST) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Last tile product lands; result half is picked from the same sum.
          acc_q      <= sum_d;
          res_q      <= hi_q ? sum_d[PW-1:WIDTH] : sum_d[WIDTH-1:0];
          prod_vld_q <= 1'b0;
          k_q        <= '0;
          state_q    <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nios_mul_seq_cell.sv
// Bench for nios_mul_seq_cell: three instances (TILE=16/32/8, i.e. N=2/1/4)
// share one stimulus stream. A negedge monitor keeps a transaction-level model
// of each instance (in-flight op, accept cycle, expected product) and checks
// out_valid, in_ready, busy and the result on every cycle. Directed tests add
// hand-computed literals.
module tb_nios_mul_seq_cell;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, sa, sb, hi;
  logic [31:0] src1, src2;
  logic [2:0]  in_ready_w, out_valid_w, busy_w;
  logic [31:0] res_w  [3];
  logic [63:0] prod_w [3];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  // Edges from the accepting edge until out_valid is seen: N*N+1.
  int lat_of [3] = '{5, 2, 17};

  always #5 clk = ~clk;

  nios_mul_seq_cell #(.WIDTH(32), .TILE(16)) dut_n2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_src1(src1), .in_src2(src2), .in_src1_signed(sa), .in_src2_signed(sb), .in_hi(hi),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_result(res_w[0]),
    .out_product(prod_w[0]), .busy(busy_w[0]));
  nios_mul_seq_cell #(.WIDTH(32), .TILE(32)) dut_n1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_src1(src1), .in_src2(src2), .in_src1_signed(sa), .in_src2_signed(sb), .in_hi(hi),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_result(res_w[1]),
    .out_product(prod_w[1]), .busy(busy_w[1]));
  nios_mul_seq_cell #(.WIDTH(32), .TILE(8)) dut_n4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_src1(src1), .in_src2(src2), .in_src1_signed(sa), .in_src2_signed(sb), .in_hi(hi),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_result(res_w[2]),
    .out_product(prod_w[2]), .busy(busy_w[2]));

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h", nm, d, act, exp);
    end
  endtask

  // Full product modulo 2^64 from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s1, input logic s2);
    longint x, y;
    x = s1 ? longint'($signed(a)) : longint'({32'b0, a});
    y = s2 ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(x * y);
  endfunction

  // Transaction-level model per instance.
  logic        exp_v   [3];
  logic [63:0] exp_p   [3];
  logic [31:0] exp_r   [3];
  int          exp_c0  [3];

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        exp_v[d] = 1'b0;
      end else begin
        logic vexp, rexp, bexp;
        vexp = exp_v[d] && ((cyc - exp_c0[d] - 1) >= lat_of[d]);
        rexp = !exp_v[d] || (vexp && out_ready);
        bexp = exp_v[d] && !vexp;
        chk("out_valid", d, 64'(out_valid_w[d]), 64'(vexp));
        chk("in_ready",  d, 64'(in_ready_w[d]),  64'(rexp));
        chk("busy",      d, 64'(busy_w[d]),      64'(bexp));
        if (vexp) begin
          chk("product", d, prod_w[d], exp_p[d]);
          chk("result",  d, 64'(res_w[d]), 64'(exp_r[d]));
          if (out_ready) exp_v[d] = 1'b0;
        end
        if (flush) begin
          exp_v[d] = 1'b0;
        end else if (in_valid && rexp) begin
          exp_v[d]  = 1'b1;
          exp_p[d]  = model(src1, src2, sa, sb);
          exp_r[d]  = hi ? exp_p[d][63:32] : exp_p[d][31:0];
          exp_c0[d] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    src1 = $urandom; src2 = $urandom;
    sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); hi = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_all_valid();
    int n = 0;
    while (out_valid_w !== 3'b111 && n < 40) begin tick(); n++; end
    if (out_valid_w !== 3'b111) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got %b want 111", out_valid_w);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s1,
                        input logic s2, input logic h, input logic [63:0] ep,
                        input logic [31:0] er);
    src1 = a; src2 = b; sa = s1; sb = s2; hi = h; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; scramble();
    wait_all_valid();
    for (int d = 0; d < 3; d++) begin
      chk("lit_product", d, prod_w[d], ep);
      chk("lit_result",  d, 64'(res_w[d]), 64'(er));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic cancel_test(input bit use_reset);
    src1 = 32'hDEADBEEF; src2 = 32'h00001234; sa = 1'b1; sb = 1'b0; hi = 1'b0; in_valid = 1'b1;
    tick();                 // accept edge; now in first MUL cycle
    in_valid = 1'b0; scramble();
    tick();                 // second MUL cycle
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    chk("cancel_in_ready", 0, 64'(in_ready_w), 64'(3'b111));
    chk("cancel_valid",    0, 64'(out_valid_w), 64'(3'b000));
    repeat (20) tick();
    chk("cancel_no_valid", 0, 64'(out_valid_w), 64'(3'b000));
    run_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 64'd42, 32'd42);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] hold_p;
    logic [31:0] hold_r;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; sa = 1'b0; sb = 1'b0; hi = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid",    d, 64'(out_valid_w[d]), 64'd0);
      chk("rst_busy",     d, 64'(busy_w[d]),      64'd0);
      chk("rst_product",  d, prod_w[d],           64'd0);
      chk("rst_result",   d, 64'(res_w[d]),       64'd0);
      chk("rst_in_ready", d, 64'(in_ready_w[d]),  64'd1);
    end
    reset = 1'b0;
    tick();

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFE_00000001, 32'h00000001);
    run_op(32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 32'hFFFFFFFF);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF_00000001, 32'h00000001);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFF_00000001, 32'h00000001);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 64'h40000000_00000000, 32'h40000000);

    // Backpressure, then transfer and new accept in the same cycle.
    src1 = 32'h12345678; src2 = 32'h9ABCDEF0; sa = 1'b0; sb = 1'b1; hi = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; scramble();
    wait_all_valid();
    hold_p = prod_w[0]; hold_r = res_w[0];
    repeat (10) begin
      tick();
      chk("bp_valid",    0, 64'(out_valid_w[0]), 64'd1);
      chk("bp_in_ready", 0, 64'(in_ready_w[0]),  64'd0);
      chk("bp_product",  0, prod_w[0], hold_p);
      chk("bp_result",   0, 64'(res_w[0]), 64'(hold_r));
    end
    src1 = 32'd3; src2 = 32'd4; sa = 1'b0; sb = 1'b0; hi = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0; scramble();
    chk("b2b_drop", 0, 64'(out_valid_w), 64'(3'b000));
    repeat (4) tick();
    chk("b2b_early", 0, 64'(out_valid_w[0]), 64'd0);
    tick();
    chk("b2b_valid",   0, 64'(out_valid_w[0]), 64'd1);
    chk("b2b_product", 0, prod_w[0], 64'h0000000C);
    chk("b2b_result",  0, 64'(res_w[0]), 64'h0000000C);
    wait_all_valid();
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    cancel_test(1'b0);
    cancel_test(1'b1);

    // Random operands, signs, half-select, stalls and back-to-back accepts.
    begin
      bit pend = 1'b0;
      for (int n = 0; n < 1500; n++) begin
        if (!pend) begin
          src1 = pick(); src2 = pick();
          sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); hi = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          tick();
          in_valid = 1'b0; scramble();
        end
        wait_all_valid();
        repeat ($urandom_range(0, 2)) tick();
        out_ready = 1'b1;
        pend = ($urandom_range(0, 3) == 0);
        if (pend) begin
          src1 = pick(); src2 = pick();
          sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); hi = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
        end
        tick();
        out_ready = 1'b0; in_valid = 1'b0; scramble();
      end
      if (pend) begin
        wait_all_valid();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
      end
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
